// File: rtl/ped_panel_pkg.sv
// Shared types and constants for the pedestrian crossing panel.
// State encoding, lamp reset values and controller count width.
package ped_panel_pkg;

   typedef enum logic [1:0] {
      IDLE,
      REQUESTED,
      WALK,
      FLASH
   } panel_state_t;

   localparam int   COUNT_W         = 3;
   localparam logic WAIT_RESET      = 1'b0;
   localparam logic WALK_RESET      = 1'b0;
   localparam logic DONT_WALK_RESET = 1'b1;

endpackage

// File: rtl/button_debouncer.sv
// Push-button synchronizer, debouncer and press-event detector.
// Emits a one-cycle press pulse on each debounced rising edge.
module button_debouncer #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic button_raw,
   output logic press
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

   logic          sync1;
   logic          sync2;
   logic          level;
   logic          level_q;
   logic [DW-1:0] cnt;

   // two-flop synchronizer for the asynchronous button
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= button_raw;
         sync2 <= sync1;
      end
   end

   // level follows the sample only after a full run of differing samples
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         level   <= 1'b0;
         level_q <= 1'b0;
         cnt     <= '0;
      end else begin
         level_q <= level;
         if (sync2 == level) begin
            cnt <= '0;
         end else if (cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
            level <= sync2;
            cnt   <= '0;
         end else begin
            cnt <= cnt + DW'(1);
         end
      end
   end

   assign press = level & ~level_q;

endmodule

// File: rtl/ped_crossing_panel.sv
// Pedestrian push-button and signal-head panel.
// Optional safety fault check: define PED_PANEL_FAULT_CHECK_EN.
module ped_crossing_panel
   import ped_panel_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int FLASH_THRESHOLD = 2,
   parameter int FLASH_HALF      = 2,
   parameter int CHIRP_HALF      = 1
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               button_raw,
   input  logic               ped_walk,
   input  logic [COUNT_W-1:0] ped_count,
   input  logic               red,
   output logic               ped_req,
   output logic               wait_lamp,
   output logic               walk_lamp,
   output logic               dont_walk_lamp,
   output logic [COUNT_W-1:0] digit,
   output logic               digit_valid,
   output logic               chirp,
   output logic               fault
);

   localparam int FW = $clog2(FLASH_HALF + 1);
   localparam int CW = $clog2(CHIRP_HALF + 1);

   panel_state_t  state;
   panel_state_t  nxt;
   logic          press;
   logic          low_count;
   logic          fault_now;
   logic          show;
   logic [FW-1:0] fcnt;
   logic [CW-1:0] ccnt;

   button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_debouncer (
      .clk       (clk),
      .reset_n   (reset_n),
      .button_raw(button_raw),
      .press     (press)
   );

   assign low_count = ped_count <= COUNT_W'(FLASH_THRESHOLD);

`ifdef PED_PANEL_FAULT_CHECK_EN
   assign fault_now = fault | (ped_walk & ~red);

   // sticky fault: walk granted while cars are not held at red
   always_ff @(posedge clk) begin
      if (!reset_n) fault <= 1'b0;
      else          fault <= fault_now;
   end
`else
   logic unused_red;
   assign unused_red = red;
   assign fault_now  = 1'b0;
   assign fault      = 1'b0;
`endif

   // next-state decode; a grant beats a same-cycle press
   always_comb begin
      nxt = state;
      unique case (state)
         IDLE, REQUESTED: begin
            if (ped_walk)
               nxt = low_count ? FLASH : WALK;
            else if (press)
               nxt = REQUESTED;
         end
         WALK: begin
            if (!ped_walk)
               nxt = IDLE;
            else if (low_count)
               nxt = FLASH;
         end
         FLASH: begin
            if (!ped_walk)
               nxt = IDLE;
         end
         default: nxt = IDLE;
      endcase
      if (fault_now)
         nxt = IDLE;
   end

   assign show = (nxt == WALK) || (nxt == FLASH);

   // state register with all panel outputs registered from next state
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state          <= IDLE;
         ped_req        <= 1'b0;
         wait_lamp      <= WAIT_RESET;
         walk_lamp      <= WALK_RESET;
         dont_walk_lamp <= DONT_WALK_RESET;
         digit          <= '0;
         digit_valid    <= 1'b0;
         chirp          <= 1'b0;
         fcnt           <= '0;
         ccnt           <= '0;
      end else begin
         state       <= nxt;
         ped_req     <= (state == IDLE) && (nxt == REQUESTED);
         wait_lamp   <= nxt == REQUESTED;
         walk_lamp   <= nxt == WALK;
         digit_valid <= show;
         digit       <= show ? ped_count : '0;

         if (nxt != WALK) begin
            chirp <= 1'b0;
            ccnt  <= '0;
         end else if (state != WALK) begin
            chirp <= 1'b1;
            ccnt  <= '0;
         end else if (ccnt == CW'(CHIRP_HALF - 1)) begin
            chirp <= ~chirp;
            ccnt  <= '0;
         end else begin
            ccnt <= ccnt + CW'(1);
         end

         if (nxt != FLASH) begin
            dont_walk_lamp <= nxt != WALK;
            fcnt           <= '0;
         end else if (state != FLASH) begin
            dont_walk_lamp <= 1'b1;
            fcnt           <= '0;
         end else if (fcnt == FW'(FLASH_HALF - 1)) begin
            dont_walk_lamp <= ~dont_walk_lamp;
            fcnt           <= '0;
         end else begin
            fcnt <= fcnt + FW'(1);
         end
      end
   end

endmodule

// File: tb/tb_ped_crossing_panel.sv
// Directed testbench for ped_crossing_panel.
// Table-driven crossing sequence plus hand-written corner cases.
module tb_ped_crossing_panel;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       button_raw = 1'b0;
   logic       ped_walk = 1'b0;
   logic [2:0] ped_count = 3'd0;
   logic       red = 1'b1;
   logic       ped_req;
   logic       wait_lamp;
   logic       walk_lamp;
   logic       dont_walk_lamp;
   logic [2:0] digit;
   logic       digit_valid;
   logic       chirp;
   logic       fault;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   ped_crossing_panel dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .button_raw    (button_raw),
      .ped_walk      (ped_walk),
      .ped_count     (ped_count),
      .red           (red),
      .ped_req       (ped_req),
      .wait_lamp     (wait_lamp),
      .walk_lamp     (walk_lamp),
      .dont_walk_lamp(dont_walk_lamp),
      .digit         (digit),
      .digit_valid   (digit_valid),
      .chirp         (chirp),
      .fault         (fault)
   );

   // {req, wait, walk, dont_walk, digit[2:0], digit_valid, chirp, fault}
   logic [9:0] obs;
   assign obs = {ped_req, wait_lamp, walk_lamp, dont_walk_lamp,
                 digit, digit_valid, chirp, fault};

   localparam logic [9:0] IDLE_O = 10'b0_0_0_1_000_0_0_0;

   typedef struct {
      logic       rst_n;
      logic       btn;
      logic       walk;
      logic [2:0] cnt;
      logic [9:0] exp;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n    = 1'b0;
      button_raw = 1'b0;
      ped_walk   = 1'b0;
      ped_count  = 3'd0;
      red        = 1'b1;
      tick();
      tick();
      reset_n = 1'b1;
   endtask

   int req_cnt;
   int first_req;
   int wait_seen;

   initial begin
      #1;
      // reset, clean press, full crossing, held button
      tbl.push_back('{1'b0, 1'b0, 1'b0, 3'd0, IDLE_O});
      tbl.push_back('{1'b0, 1'b0, 1'b0, 3'd0, IDLE_O});
      for (int i = 1; i <= 6; i++)
         tbl.push_back('{1'b1, 1'b1, 1'b0, 3'd0, IDLE_O});
      tbl.push_back('{1'b1, 1'b1, 1'b0, 3'd0, 10'b1_1_0_1_000_0_0_0});
      tbl.push_back('{1'b1, 1'b1, 1'b0, 3'd0, 10'b0_1_0_1_000_0_0_0});
      tbl.push_back('{1'b1, 1'b1, 1'b1, 3'd5, 10'b0_0_1_0_101_1_1_0});
      tbl.push_back('{1'b1, 1'b1, 1'b1, 3'd4, 10'b0_0_1_0_100_1_0_0});
      tbl.push_back('{1'b1, 1'b1, 1'b1, 3'd3, 10'b0_0_1_0_011_1_1_0});
      tbl.push_back('{1'b1, 1'b1, 1'b1, 3'd2, 10'b0_0_0_1_010_1_0_0});
      tbl.push_back('{1'b1, 1'b1, 1'b1, 3'd1, 10'b0_0_0_1_001_1_0_0});
      tbl.push_back('{1'b1, 1'b1, 1'b1, 3'd0, 10'b0_0_0_0_000_1_0_0});
      tbl.push_back('{1'b1, 1'b1, 1'b1, 3'd0, 10'b0_0_0_0_000_1_0_0});
      tbl.push_back('{1'b1, 1'b1, 1'b1, 3'd3, 10'b0_0_0_1_011_1_0_0});
      tbl.push_back('{1'b1, 1'b1, 1'b0, 3'd0, IDLE_O});
      tbl.push_back('{1'b1, 1'b1, 1'b0, 3'd0, IDLE_O});
      tbl.push_back('{1'b1, 1'b1, 1'b0, 3'd0, IDLE_O});

      red = 1'b1;
      for (int i = 0; i < tbl.size(); i++) begin
         reset_n    = tbl[i].rst_n;
         button_raw = tbl[i].btn;
         ped_walk   = tbl[i].walk;
         ped_count  = tbl[i].cnt;
         tick();
         chk($sformatf("row%0d", i), 32'(obs), 32'(tbl[i].exp));
      end

      // bounce 1,0,1,1,0 then stable high: one pulse after edge 12
      do_reset();
      req_cnt   = 0;
      first_req = 0;
      for (int e = 1; e <= 30; e++) begin
         case (e)
            1, 3, 4: button_raw = 1'b1;
            2, 5:    button_raw = 1'b0;
            default: button_raw = 1'b1;
         endcase
         tick();
         if (ped_req) begin
            req_cnt++;
            if (first_req == 0) first_req = e;
         end
      end
      chk("bounce_pulses", 32'(req_cnt), 32'd1);
      chk("bounce_edge", 32'(first_req), 32'd12);
      chk("bounce_wait", 32'(wait_lamp), 32'd1);

      // foreign grant in the same cycle as a press
      do_reset();
      req_cnt   = 0;
      wait_seen = 0;
      for (int e = 1; e <= 20; e++) begin
         button_raw = 1'b1;
         ped_walk   = (e >= 7) && (e <= 10);
         ped_count  = 3'd5;
         tick();
         if (ped_req) req_cnt++;
         if (wait_lamp) wait_seen++;
         if (e == 7) begin
            chk("grant_walk", 32'(walk_lamp), 32'd1);
            chk("grant_digit", 32'(digit), 32'd5);
         end
      end
      chk("grant_no_req", 32'(req_cnt), 32'd0);
      chk("grant_no_wait", 32'(wait_seen), 32'd0);
      chk("grant_idle", 32'(obs), 32'(IDLE_O));

      // reset mid-walk, then a normal request
      do_reset();
      ped_walk  = 1'b1;
      ped_count = 3'd5;
      tick();
      tick();
      chk("mid_walk", 32'(walk_lamp), 32'd1);
      reset_n  = 1'b0;
      ped_walk = 1'b0;
      tick();
      chk("mid_reset", 32'(obs), 32'(IDLE_O));
      reset_n   = 1'b1;
      req_cnt   = 0;
      first_req = 0;
      for (int e = 1; e <= 15; e++) begin
         button_raw = 1'b1;
         tick();
         if (ped_req) begin
            req_cnt++;
            if (first_req == 0) first_req = e;
         end
      end
      chk("post_reset_edge", 32'(first_req), 32'd7);
      chk("post_reset_pulses", 32'(req_cnt), 32'd1);
      chk("post_reset_wait", 32'(wait_lamp), 32'd1);

      // walk granted without car red
      do_reset();
      ped_walk  = 1'b1;
      ped_count = 3'd5;
      red       = 1'b0;
      tick();
`ifdef PED_PANEL_FAULT_CHECK_EN
      chk("fault_set", 32'(obs), 32'(10'b0_0_0_1_000_0_0_1));
      ped_walk = 1'b0;
      red      = 1'b1;
      req_cnt  = 0;
      for (int e = 1; e <= 12; e++) begin
         button_raw = 1'b1;
         tick();
         if (ped_req) req_cnt++;
      end
      chk("fault_no_req", 32'(req_cnt), 32'd0);
      chk("fault_sticky", 32'(obs), 32'(10'b0_0_0_1_000_0_0_1));
      do_reset();
      chk("fault_cleared", 32'(fault), 32'd0);
`else
      chk("nofault_walk", 32'(obs), 32'(10'b0_0_1_0_101_1_1_0));
      ped_walk = 1'b0;
      red      = 1'b1;
      tick();
      chk("nofault_idle", 32'(obs), 32'(IDLE_O));
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
